// File: rtl/stream_xbar_param.sv
// Parameterised stream crossbar. Every output owns a one-entry buffer
// that is fed from the input chosen by its select field. An input
// fires only when every output selecting it can take the word, so a
// word shared by several outputs reaches all of them or none of them.
// A new select vector is held in a pending register and committed
// only after all buffers have emptied. The override inputs redirect
// every output at once and do not touch the committed vector.
module stream_xbar_param #(
  parameter int N_IN      = 4,
  parameter int N_OUT     = 4,
  parameter int BIT_WIDTH = 32,
  localparam int SEL_W    = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int CFG_W    = N_OUT * SEL_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_IN*BIT_WIDTH-1:0]  recv_msg,
  input  logic [N_IN-1:0]            recv_val,
  output logic [N_IN-1:0]            recv_rdy,
  output logic [N_OUT*BIT_WIDTH-1:0] send_msg,
  output logic [N_OUT-1:0]           send_val,
  input  logic [N_OUT-1:0]           send_rdy,
  input  logic [CFG_W-1:0]           cfg_msg,
  input  logic                       cfg_val,
  output logic                       cfg_rdy,
  input  logic                       override_en,
  input  logic [SEL_W-1:0]           override_sel,
  output logic                       busy
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  // Reset value of the select vector: output j listens to input j mod N_IN.
  function automatic logic [CFG_W-1:0] reset_cfg();
    logic [CFG_W-1:0] v;
    v = '0;
    for (int j = 0; j < N_OUT; j++) begin
      v[j*SEL_W +: SEL_W] = SEL_W'(j % N_IN);
    end
    return v;
  endfunction

  localparam logic [CFG_W-1:0] RESET_CFG = reset_cfg();

  state_t               state, state_next;
  logic [CFG_W-1:0]     cfg_q, pend_q;
  logic                 pend_load, cfg_commit;
  logic [N_OUT-1:0]     full_q;
  logic [BIT_WIDTH-1:0] data_q   [N_OUT];
  logic [BIT_WIDTH-1:0] cap_data [N_OUT];
  logic [SEL_W-1:0]     sel      [N_OUT];
  logic [N_OUT-1:0]     out_en, can_acc, load;
  logic [N_IN-1:0]      rdy_int, fire;
  logic                 drain_done;

  // Effective select per output; an out-of-range index disables that output.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      sel[j]     = override_en ? override_sel : cfg_q[j*SEL_W +: SEL_W];
      out_en[j]  = (32'(sel[j]) < N_IN);
      can_acc[j] = !full_q[j] || send_rdy[j];
    end
  end

  // An input is ready only in RUN, only if something listens to it, and only if all listeners can accept.
  always_comb begin
    rdy_int = '0;
    for (int i = 0; i < N_IN; i++) begin
      logic hit;
      logic ok;
      hit = 1'b0;
      ok  = 1'b1;
      for (int j = 0; j < N_OUT; j++) begin
        if (out_en[j] && (32'(sel[j]) == i)) begin
          hit = 1'b1;
          if (!can_acc[j]) ok = 1'b0;
        end
      end
      rdy_int[i] = (state == RUN) && hit && ok;
    end
  end

  assign recv_rdy   = rdy_int;
  assign fire       = recv_val & rdy_int;
  assign drain_done = &can_acc;

  // Per-output capture strobe and data mux driven by the input that fired.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      load[j]     = 1'b0;
      cap_data[j] = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (32'(sel[j]) == i) begin
          cap_data[j] = recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
          if (out_en[j] && fire[i]) load[j] = 1'b1;
        end
      end
    end
  end

  // Next-state logic: capture a config in RUN, commit it once the buffers are empty.
  always_comb begin
    state_next = state;
    pend_load  = 1'b0;
    cfg_commit = 1'b0;
    case (state)
      RUN: begin
        if (cfg_val) begin
          pend_load  = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          cfg_commit = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign cfg_rdy = (state == RUN);
  assign busy    = (state == DRAIN);

  // State, pending and committed configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      cfg_q  <= RESET_CFG;
      pend_q <= RESET_CFG;
    end else begin
      state <= state_next;
      if (pend_load)  pend_q <= cfg_msg;
      if (cfg_commit) cfg_q  <= pend_q;
    end
  end

  // Output buffers: a dequeue and a new capture can happen on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= '0;
      for (int j = 0; j < N_OUT; j++) data_q[j] <= '0;
    end else begin
      full_q <= load | (full_q & ~send_rdy);
      for (int j = 0; j < N_OUT; j++) begin
        if (load[j]) data_q[j] <= cap_data[j];
      end
    end
  end

  // Pack the buffers onto the output bus.
  always_comb begin
    send_msg = '0;
    for (int j = 0; j < N_OUT; j++) begin
      send_msg[j*BIT_WIDTH +: BIT_WIDTH] = data_q[j];
    end
  end

  assign send_val = full_q;

endmodule

// File: tb/tb_stream_xbar_param.sv
// Bench for stream_xbar_param with default parameters. A monitor samples
// the ports one time unit before every rising edge, pushes each input
// fire into the queues of the outputs that the bench expects to select
// that input, and pops/compares on every output dequeue.
module tb_stream_xbar_param;

  localparam int N_IN  = 4;
  localparam int N_OUT = 4;
  localparam int BW    = 32;
  localparam int SEL_W = 2;
  localparam int CFG_W = 8;

  localparam logic [CFG_W-1:0] CFG_DEF  = 8'hE4;
  localparam logic [CFG_W-1:0] CFG_ALL2 = 8'hAA;
  localparam logic [CFG_W-1:0] CFG_ALL0 = 8'h00;

  logic                  clk;
  logic                  reset;
  logic [N_IN*BW-1:0]    recv_msg;
  logic [N_IN-1:0]       recv_val;
  logic [N_IN-1:0]       recv_rdy;
  logic [N_OUT*BW-1:0]   send_msg;
  logic [N_OUT-1:0]      send_val;
  logic [N_OUT-1:0]      send_rdy;
  logic [CFG_W-1:0]      cfg_msg;
  logic                  cfg_val;
  logic                  cfg_rdy;
  logic                  override_en;
  logic [SEL_W-1:0]      override_sel;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0]    sb [N_OUT][$];
  logic [CFG_W-1:0] tb_cfg = CFG_DEF;

  stream_xbar_param #(.N_IN(N_IN), .N_OUT(N_OUT), .BIT_WIDTH(BW)) dut (
    .clk(clk), .reset(reset),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .cfg_msg(cfg_msg), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
    .override_en(override_en), .override_sel(override_sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] word(input int i, input int k);
    return BW'(32'hA0 + i + (k << 8));
  endfunction

  function automatic logic [N_OUT*BW-1:0] exp_straight(input int k);
    logic [N_OUT*BW-1:0] v;
    for (int j = 0; j < N_OUT; j++) v[j*BW +: BW] = word(j, k);
    return v;
  endfunction

  function automatic logic [N_OUT*BW-1:0] exp_bcast(input int i, input int k);
    logic [N_OUT*BW-1:0] v;
    for (int j = 0; j < N_OUT; j++) v[j*BW +: BW] = word(i, k);
    return v;
  endfunction

  task automatic drive_inputs(input logic [N_IN-1:0] val, input int k);
    recv_val = val;
    for (int i = 0; i < N_IN; i++) recv_msg[i*BW +: BW] = word(i, k);
  endtask

  // Scoreboard monitor.
  always begin
    logic [BW-1:0]    exp;
    logic [SEL_W-1:0] s;
    bit               hit;
    @(negedge clk);
    #4;
    if (!reset) begin
      for (int j = 0; j < N_OUT; j++) sb[j].delete();
      tb_cfg = CFG_DEF;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (send_val[j] && send_rdy[j]) begin
          n_checks++;
          if (sb[j].size() == 0) begin
            n_fail++;
            $display("[TB] FAIL sb_unexpected out%0d: got %h, required no word", j, send_msg[j*BW +: BW]);
          end else begin
            exp = sb[j].pop_front();
            if (send_msg[j*BW +: BW] !== exp) begin
              n_fail++;
              $display("[TB] FAIL sb_data out%0d: got %h, required %h", j, send_msg[j*BW +: BW], exp);
            end
          end
        end
      end
      for (int j = 0; j < N_OUT; j++) begin
        s = override_en ? override_sel : tb_cfg[j*SEL_W +: SEL_W];
        if (recv_val[s] && recv_rdy[s]) sb[j].push_back(recv_msg[s*BW +: BW]);
      end
      for (int i = 0; i < N_IN; i++) begin
        hit = 1'b0;
        for (int j = 0; j < N_OUT; j++) begin
          s = override_en ? override_sel : tb_cfg[j*SEL_W +: SEL_W];
          if (32'(s) == i) hit = 1'b1;
        end
        if (!hit) begin
          n_checks++;
          if (recv_rdy[i] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL unselected_rdy in%0d: got %b, required 0", i, recv_rdy[i]);
          end
        end
      end
      if (cfg_val && cfg_rdy) tb_cfg = cfg_msg;
    end
  end

  task automatic wait_drain();
    bit done;
    recv_val = '0;
    send_rdy = '1;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = (send_val == '0) && (sb[0].size() == 0) && (sb[1].size() == 0)
             && (sb[2].size() == 0) && (sb[3].size() == 0);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL drain_empty: got send_val=%b queued=%0d/%0d/%0d/%0d, required all empty",
               send_val, sb[0].size(), sb[1].size(), sb[2].size(), sb[3].size());
    end
  endtask

  task automatic do_cfg(input logic [CFG_W-1:0] v);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = cfg_rdy;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL cfg_rdy_timeout: got 0, required 1");
    end
    cfg_msg = v;
    cfg_val = 1'b1;
    @(negedge clk);
    cfg_val = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = !busy;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL cfg_commit_timeout: got busy=1, required 0");
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    recv_msg = '0; recv_val = '0; send_rdy = '1;
    cfg_msg = '0; cfg_val = 1'b0; override_en = 1'b0; override_sel = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (send_val !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_send_val: got %b, required 0000", send_val); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (cfg_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_cfg_rdy: got %b, required 1", cfg_rdy); end
    n_checks++;
    if (send_msg !== '0) begin n_fail++; $display("[TB] FAIL reset_send_msg: got %h, required 0", send_msg); end
    n_checks++;
    if (recv_rdy !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_recv_rdy: got %b, required 1111", recv_rdy); end
  endtask

  task automatic test_defaults();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_checks++;
        if (send_val !== 4'hF) begin n_fail++; $display("[TB] FAIL defaults_val k=%0d: got %b, required 1111", k-1, send_val); end
        n_checks++;
        if (send_msg !== exp_straight(k-1)) begin
          n_fail++; $display("[TB] FAIL defaults_msg k=%0d: got %h, required %h", k-1, send_msg, exp_straight(k-1));
        end
      end
      drive_inputs(4'hF, k);
    end
    @(negedge clk);
    n_checks++;
    if (send_msg !== exp_straight(9)) begin
      n_fail++; $display("[TB] FAIL defaults_last: got %h, required %h", send_msg, exp_straight(9));
    end
    wait_drain();
  endtask

  task automatic test_drain();
    @(negedge clk);
    send_rdy = 4'b1101;
    drive_inputs(4'b0010, 20);
    @(negedge clk);
    recv_val = '0;
    n_checks++;
    if (send_val !== 4'b0010) begin n_fail++; $display("[TB] FAIL drain_fill: got %b, required 0010", send_val); end
    cfg_msg = CFG_ALL2;
    cfg_val = 1'b1;
    @(negedge clk);
    cfg_val = 1'b0;
    drive_inputs(4'hF, 21);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_busy c=%0d: got %b, required 1", c, busy); end
      n_checks++;
      if (recv_rdy !== 4'h0) begin n_fail++; $display("[TB] FAIL drain_recv_rdy c=%0d: got %b, required 0000", c, recv_rdy); end
      n_checks++;
      if (cfg_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_cfg_rdy c=%0d: got %b, required 0", c, cfg_rdy); end
    end
    @(negedge clk);
    send_rdy = 4'hF;
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_pre_commit: got %b, required 1", busy); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || cfg_rdy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL drain_commit: got busy=%b cfg_rdy=%b, required busy=0 cfg_rdy=1", busy, cfg_rdy);
    end
    n_checks++;
    if (recv_rdy !== 4'b0100) begin n_fail++; $display("[TB] FAIL drain_new_cfg: got %b, required 0100", recv_rdy); end
    recv_val = '0;
    wait_drain();
  endtask

  task automatic test_multicast();
    @(negedge clk);
    send_rdy = 4'b1011;
    drive_inputs(4'b0100, 30);
    #1;
    n_checks++;
    if (recv_rdy !== 4'b0100) begin n_fail++; $display("[TB] FAIL mcast_rdy0: got %b, required 0100", recv_rdy); end
    @(negedge clk);
    n_checks++;
    if (send_val !== 4'hF || send_msg !== exp_bcast(2, 30)) begin
      n_fail++; $display("[TB] FAIL mcast_first: got val=%b msg=%h, required 1111 %h", send_val, send_msg, exp_bcast(2, 30));
    end
    drive_inputs(4'b0100, 31);
    #1;
    n_checks++;
    if (recv_rdy !== 4'b0000) begin n_fail++; $display("[TB] FAIL mcast_block: got %b, required 0000", recv_rdy); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_inputs(4'b0100, 32 + c);
      n_checks++;
      if (send_val !== 4'b0100 || send_msg[2*BW +: BW] !== word(2, 30) || recv_rdy !== 4'b0000) begin
        n_fail++; $display("[TB] FAIL mcast_hold c=%0d: got val=%b msg2=%h rdy=%b, required 0100 %h 0000",
                           c, send_val, send_msg[2*BW +: BW], recv_rdy, word(2, 30));
      end
    end
    @(negedge clk);
    send_rdy = 4'hF;
    drive_inputs(4'b0100, 40);
    #1;
    n_checks++;
    if (recv_rdy !== 4'b0100) begin n_fail++; $display("[TB] FAIL mcast_release: got %b, required 0100", recv_rdy); end
    @(negedge clk);
    n_checks++;
    if (send_val !== 4'hF || send_msg !== exp_bcast(2, 40)) begin
      n_fail++; $display("[TB] FAIL mcast_all: got val=%b msg=%h, required 1111 %h", send_val, send_msg, exp_bcast(2, 40));
    end
    wait_drain();
  endtask

  task automatic test_unselected();
    do_cfg(CFG_ALL0);
    send_rdy = 4'hF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive_inputs(4'hF, 50 + c);
      #1;
      n_checks++;
      if (recv_rdy !== 4'b0001) begin n_fail++; $display("[TB] FAIL unsel_rdy c=%0d: got %b, required 0001", c, recv_rdy); end
    end
    @(negedge clk);
    n_checks++;
    if (send_msg !== exp_bcast(0, 69)) begin
      n_fail++; $display("[TB] FAIL unsel_last: got %h, required %h", send_msg, exp_bcast(0, 69));
    end
    wait_drain();
  endtask

  task automatic test_override();
    do_cfg(CFG_DEF);
    send_rdy = 4'hF;
    for (int k = 60; k < 63; k++) begin
      @(negedge clk);
      drive_inputs(4'hF, k);
    end
    @(negedge clk);
    drive_inputs(4'hF, 63);
    override_en = 1'b1;
    override_sel = 2'd3;
    #1;
    n_checks++;
    if (recv_rdy !== 4'b1000) begin n_fail++; $display("[TB] FAIL ovr_rdy: got %b, required 1000", recv_rdy); end
    for (int k = 64; k < 66; k++) begin
      @(negedge clk);
      n_checks++;
      if (send_msg !== exp_bcast(3, k-1)) begin
        n_fail++; $display("[TB] FAIL ovr_data k=%0d: got %h, required %h", k-1, send_msg, exp_bcast(3, k-1));
      end
      drive_inputs(4'hF, k);
    end
    @(negedge clk);
    drive_inputs(4'hF, 66);
    override_en = 1'b0;
    #1;
    n_checks++;
    if (recv_rdy !== 4'hF) begin n_fail++; $display("[TB] FAIL ovr_restore_rdy: got %b, required 1111", recv_rdy); end
    @(negedge clk);
    n_checks++;
    if (send_val !== 4'hF || send_msg !== exp_straight(66)) begin
      n_fail++; $display("[TB] FAIL ovr_restore: got val=%b msg=%h, required 1111 %h", send_val, send_msg, exp_straight(66));
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      drive_inputs(4'($urandom_range(0, 15)), 100 + c);
      send_rdy = 4'($urandom_range(0, 15));
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    send_rdy = 4'h0;
    drive_inputs(4'hF, 90);
    @(negedge clk);
    recv_val = '0;
    n_checks++;
    if (send_val !== 4'hF) begin n_fail++; $display("[TB] FAIL rst_mid_fill: got %b, required 1111", send_val); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (send_val !== 4'h0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_mid_async: got val=%b busy=%b, required 0000 0", send_val, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    send_rdy = 4'hF;
    @(negedge clk);
    n_checks++;
    if (send_val !== 4'h0 || send_msg !== '0) begin
      n_fail++; $display("[TB] FAIL rst_mid_discard: got val=%b msg=%h, required 0000 0", send_val, send_msg);
    end
    drive_inputs(4'hF, 95);
    @(negedge clk);
    n_checks++;
    if (send_val !== 4'hF || send_msg !== exp_straight(95)) begin
      n_fail++; $display("[TB] FAIL rst_mid_refire: got val=%b msg=%h, required 1111 %h", send_val, send_msg, exp_straight(95));
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_drain();
    test_multicast();
    test_unselected();
    test_override();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/stream_xbar_param.md
STREAM_XBAR_PARAM -- requirements
Module: stream_xbar_param

Interface
REQ-001 Parameter N_IN, default 4, number of input streams (>=2).
REQ-002 Parameter N_OUT, default 4, number of output streams (>=1).
REQ-003 Parameter BIT_WIDTH, default 32, message width.
REQ-004 Derived SEL_W = max(1, clog2(N_IN)); CFG_W = N_OUT*SEL_W.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-007 recv_msg  in  N_IN*BIT_WIDTH  input messages, input i at bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-008 recv_val  in  N_IN  per-input valid.
REQ-009 recv_rdy  out  N_IN  per-input ready.
REQ-010 send_msg  out  N_OUT*BIT_WIDTH  output messages, same packing.
REQ-011 send_val  out  N_OUT  per-output valid.
REQ-012 send_rdy  in  N_OUT  per-output ready.
REQ-013 cfg_msg  in  CFG_W  new select vector; output j select at [j*SEL_W +: SEL_W].
REQ-014 cfg_val / cfg_rdy  in / out  1 / 1  config handshake.
REQ-015 override_en  in  1  force all outputs to override_sel.
REQ-016 override_sel  in  SEL_W  forced input index.
REQ-017 busy  out  1  high while in DRAIN state.

Function
REQ-018 Each output j SHALL own a 1-entry pipeline buffer; send_val[j] = buffer full; send_msg[j] = buffer data.
REQ-019 Effective select sel_j SHALL be override_sel when override_en=1, else committed config field j; evaluated combinationally each cycle.
REQ-020 sel_j >= N_IN SHALL disable output j: it never captures, its full buffer still drains.
REQ-021 Output j SHALL be able to accept when buffer empty, or full with send_rdy[j]=1 (same-cycle dequeue and enqueue).
REQ-022 recv_rdy[i] SHALL be 1 only in RUN, when at least one enabled output selects i, and all outputs selecting i can accept.
REQ-023 An input with no selecting output SHALL hold recv_rdy[i]=0 (no drop).
REQ-024 Input fire (recv_val[i] & recv_rdy[i]) SHALL load recv_msg[i] into every output selecting i in the same edge (multicast, all-or-none).
REQ-025 Latency recv fire to send_val SHALL be exactly 1 cycle; full throughput of 1 message/cycle/output.
REQ-026 FSM states RUN, DRAIN; cfg_rdy = 1 only in RUN.
REQ-027 RUN: cfg_val & cfg_rdy latches cfg_msg into pending register, next state DRAIN.
REQ-028 DRAIN: busy=1, all recv_rdy=0, buffers continue dequeuing; when all buffers empty (including empty after this cycle's dequeues), pending commits to config at that edge and next state RUN.
REQ-029 Config capture during DRAIN SHALL be impossible; a second cfg_val is held until RUN.
REQ-030 override_en/override_sel changes SHALL take effect the same cycle, without draining; messages already buffered are unaffected.
REQ-031 Override SHALL NOT alter committed config; dropping override_en restores it immediately.
REQ-032 No message SHALL be duplicated, lost or reordered per output under any send_rdy pattern.

Reset
REQ-033 reset=0 SHALL force: state RUN, all buffers empty, send_val=0, busy=0, cfg_rdy=1 after release, committed and pending config field j = j mod N_IN.
REQ-034 Reset mid-transfer SHALL discard buffered data; first send_val after release needs a new input fire.
REQ-035 recv_rdy SHALL be combinational from state; send_msg value while send_val=0 is don't-care but defined as 0 after reset.

Verification
REQ-036 Defaults, after reset: recv_val=4'hF, msg i = 32'hA0+i, all send_rdy=1 -> next cycle send_msg j = 32'hA0+j, send_val=4'hF, sustained 1/cycle.
REQ-037 Multicast: cfg_msg selects input 2 for all outputs; send_rdy=4'b1011 held -> recv_rdy[2]=0 once output 2 full, no output receives a new word until send_rdy[2]=1, then all four receive identical data.
REQ-038 Reconfig drain: output 1 full with send_rdy[1]=0, cfg_val pulse -> busy=1, recv_rdy=0 for all inputs; raising send_rdy[1] after 5 cycles -> commit that edge, busy=0, RUN next cycle.
REQ-039 Override: override_en=1, override_sel=3 mid-stream -> next capture on every output is input 3 data; override_en=0 -> defaults resume without gap or duplicate.
REQ-040 Unselected input: N_IN=4, all outputs select 0 -> recv_rdy[3:1]=0 while recv_val[3:1]=1 for 20 cycles, no loss on input 0.
REQ-041 Async reset asserted between clock edges with buffers full -> send_val=0 immediately, before next edge.
